// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response bus between mem_access_unit and data_cache
interface mem_access_unit_if;
    logic [3:0]  READ_WRITE;
    logic [31:0] ADDRESS;
    logic [31:0] WRITEDATA;
    logic [31:0] READDATA;
    logic        BUSYWAIT;

    modport master (
        output READ_WRITE, ADDRESS, WRITEDATA,
        input  READDATA, BUSYWAIT
    );

    modport slave (
        input  READ_WRITE, ADDRESS, WRITEDATA,
        output READDATA, BUSYWAIT
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage initiator: issues load/store to data_cache, stalls, counts stalls
module mem_access_unit #(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   MEM_READ_EN,
    input  logic                   MEM_WRITE_EN,
    input  logic [2:0]             FUNCT3,
    input  logic [31:0]            ALU_RESULT,
    input  logic [31:0]            STORE_DATA,
    output logic                   STALL,
    output logic [31:0]            LOAD_DATA,
    output logic                   LOAD_VALID,
    output logic                   MISALIGNED,
    output logic [STALL_CNT_W-1:0] STALL_COUNT,
    mem_access_unit_if.master      cache
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] req_op;
    logic       req_legal;
    logic       req_aligned;
    logic       accept;
    logic       complete;
    logic       misaligned_req;
    logic       access_is_load;

    // Store ops are remapped into the cache's op space; loads pass funct3 through.
    always_comb begin
        req_op    = 3'b000;
        req_legal = 1'b0;
        if (MEM_WRITE_EN) begin
            case (FUNCT3)
                3'b000:  begin req_op = 3'b110; req_legal = 1'b1; end
                3'b001:  begin req_op = 3'b111; req_legal = 1'b1; end
                3'b010:  begin req_op = 3'b011; req_legal = 1'b1; end
                default: begin req_op = 3'b000; req_legal = 1'b0; end
            endcase
        end else if (MEM_READ_EN) begin
            case (FUNCT3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: begin
                    req_op    = FUNCT3;
                    req_legal = 1'b1;
                end
                default: begin
                    req_op    = 3'b000;
                    req_legal = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        req_aligned = 1'b1;
        if (FUNCT3[1:0] == 2'b10) begin
            req_aligned = (ALU_RESULT[1:0] == 2'b00);
        end else if (FUNCT3[1:0] == 2'b01) begin
            req_aligned = ~ALU_RESULT[0];
        end
    end

    assign misaligned_req = (state == IDLE) && req_legal && !req_aligned;
    assign access_is_load = !((cache.READ_WRITE[2:0] == 3'b011) || (cache.READ_WRITE[2:1] == 2'b11));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Nothing may be accepted while reset is held, so STALL is masked by it.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        complete   = 1'b0;
        STALL      = 1'b0;
        case (state)
            IDLE: begin
                if (req_legal && req_aligned) begin
                    accept     = 1'b1;
                    state_next = ACCESS;
                end
                STALL = accept && !RESET;
            end
            ACCESS: begin
                if (!cache.BUSYWAIT) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
                STALL = cache.BUSYWAIT && !RESET;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cache.READ_WRITE <= 4'b0000;
            cache.ADDRESS    <= 32'h0;
            cache.WRITEDATA  <= 32'h0;
            LOAD_DATA        <= 32'h0;
            LOAD_VALID       <= 1'b0;
            MISALIGNED       <= 1'b0;
            STALL_COUNT      <= '0;
        end else begin
            MISALIGNED <= misaligned_req;
            LOAD_VALID <= complete && access_is_load;
            if (accept) begin
                cache.READ_WRITE <= {1'b1, req_op};
                cache.ADDRESS    <= ALU_RESULT;
                cache.WRITEDATA  <= STORE_DATA;
            end else if (complete) begin
                cache.READ_WRITE <= 4'b0000;
                if (access_is_load) begin
                    LOAD_DATA <= cache.READDATA;
                end
            end
            if (STALL && !(&STALL_COUNT)) begin
                STALL_COUNT <= STALL_COUNT + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed bench with transaction-level model for mem_access_unit
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        MEM_READ_EN = 1'b0;
    logic        MEM_WRITE_EN = 1'b0;
    logic [2:0]  FUNCT3 = 3'b000;
    logic [31:0] ALU_RESULT = 32'h0;
    logic [31:0] STORE_DATA = 32'h0;
    logic        STALL;
    logic [31:0] LOAD_DATA;
    logic        LOAD_VALID;
    logic        MISALIGNED;
    logic [31:0] STALL_COUNT;

    mem_access_unit_if bus ();

    mem_access_unit #(.STALL_CNT_W(32)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .MEM_READ_EN  (MEM_READ_EN),
        .MEM_WRITE_EN (MEM_WRITE_EN),
        .FUNCT3       (FUNCT3),
        .ALU_RESULT   (ALU_RESULT),
        .STORE_DATA   (STORE_DATA),
        .STALL        (STALL),
        .LOAD_DATA    (LOAD_DATA),
        .LOAD_VALID   (LOAD_VALID),
        .MISALIGNED   (MISALIGNED),
        .STALL_COUNT  (STALL_COUNT),
        .cache        (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cache contents seen by the bench; READDATA is extended here per op.
    logic [31:0] mem [int];

    function automatic logic [31:0] cache_rd(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] sh;
        w  = mem.exists(int'(a >> 2)) ? mem[int'(a >> 2)] : 32'h0;
        sh = w >> (8 * a[1:0]);
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    // Model: op number (or -1 for no-op) from the load/store table.
    function automatic int model_op(input logic rd, input logic wr, input logic [2:0] f3);
        if (wr) begin
            if (f3 == 3'd0) return 6;
            if (f3 == 3'd1) return 7;
            if (f3 == 3'd2) return 3;
            return -1;
        end
        if (rd && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return int'(f3);
        return -1;
    endfunction

    function automatic int access_bytes(input int op);
        if (op == 0 || op == 4 || op == 6) return 1;
        if (op == 1 || op == 5 || op == 7) return 2;
        return 4;
    endfunction

    function automatic bit is_load_op(input int op);
        return op == 0 || op == 1 || op == 2 || op == 4 || op == 5;
    endfunction

    bit          m_busy;
    logic [3:0]  m_rw;
    logic [31:0] m_addr, m_wd, m_ld, m_cnt;
    logic        m_lv, m_mis;
    int          m_op;
    bit          m_st;

    function automatic bit model_stall();
        int op;
        if (m_busy) return bus.BUSYWAIT;
        op = model_op(MEM_READ_EN, MEM_WRITE_EN, FUNCT3);
        return (op >= 0) && ((ALU_RESULT % 32'(access_bytes(op))) == 0);
    endfunction

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_busy = 0; m_rw = 0; m_addr = 0; m_wd = 0; m_ld = 0;
            m_cnt = 0; m_lv = 0; m_mis = 0;
        end else begin
            m_st = model_stall();
            m_op = model_op(MEM_READ_EN, MEM_WRITE_EN, FUNCT3);
            if (m_st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            m_lv = 0;
            m_mis = 0;
            if (!m_busy) begin
                if (m_op >= 0) begin
                    if ((ALU_RESULT % 32'(access_bytes(m_op))) == 0) begin
                        m_busy = 1;
                        m_rw   = {1'b1, m_op[2:0]};
                        m_addr = ALU_RESULT;
                        m_wd   = STORE_DATA;
                    end else begin
                        m_mis = 1;
                    end
                end
            end else if (!bus.BUSYWAIT) begin
                m_busy = 0;
                if (is_load_op(int'(m_rw[2:0]))) begin
                    m_lv = 1;
                    m_ld = bus.READDATA;
                end
                m_rw = 0;
            end
        end
    end

    int stall_cyc = 0, lv_cnt = 0, mis_cnt = 0, cyc = 0;
    int rw_hist [16];
    logic [31:0] lv_q [$];

    always @(negedge CLK) begin
        if (!RESET) begin
            chk("stall", STALL, model_stall());
            chk("read_write", bus.READ_WRITE, m_rw);
            chk("address", bus.ADDRESS, m_addr);
            chk("writedata", bus.WRITEDATA, m_wd);
            chk("load_valid", LOAD_VALID, m_lv);
            chk("load_data", LOAD_DATA, m_ld);
            chk("misaligned", MISALIGNED, m_mis);
            chk("stall_count", STALL_COUNT, m_cnt);
            chk("lv_mis_exclusive", LOAD_VALID & MISALIGNED, 1'b0);
            cyc++;
            if (STALL) stall_cyc++;
            if (MISALIGNED) mis_cnt++;
            if (LOAD_VALID) begin
                lv_cnt++;
                lv_q.push_back(LOAD_DATA);
            end
            rw_hist[bus.READ_WRITE]++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // One accepted access with k busy cycles; returns one step after the completion edge.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sd, input int k);
        MEM_READ_EN = rd; MEM_WRITE_EN = wr; FUNCT3 = f3; ALU_RESULT = addr; STORE_DATA = sd;
        @(posedge CLK);
        #1;
        MEM_READ_EN = 0; MEM_WRITE_EN = 0;
        bus.READDATA = cache_rd(f3, addr);
        bus.BUSYWAIT = (k > 0);
        for (int i = 0; i < k; i++) begin
            @(posedge CLK);
            #1;
            if (i == k - 1) bus.BUSYWAIT = 0;
        end
        if (wr && f3 == 3'b010) mem[int'(addr >> 2)] = sd;
        @(posedge CLK);
        #1;
    endtask

    task automatic present_one(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr);
        MEM_READ_EN = rd; MEM_WRITE_EN = wr; FUNCT3 = f3; ALU_RESULT = addr;
        @(posedge CLK);
        #1;
        MEM_READ_EN = 0; MEM_WRITE_EN = 0;
    endtask

    int s_stall, s_lv, s_mis, s_rw, s_cyc, s_nz;

    function automatic int nonzero_rw();
        int s = 0;
        for (int i = 1; i < 16; i++) s += rw_hist[i];
        return s;
    endfunction

    task automatic snap();
        s_stall = stall_cyc; s_lv = lv_cnt; s_mis = mis_cnt; s_cyc = cyc; s_nz = nonzero_rw();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rw_hist[i] = 0;
        bus.BUSYWAIT = 0;
        bus.READDATA = 32'h0;
        mem[4] = 32'h1111_2222;
        mem[5] = 32'h3333_4444;
        idle(2);
        RESET = 0;
        idle(1);
        chk("reset_stall_count", STALL_COUNT, 32'd0);
        chk("reset_read_write", bus.READ_WRITE, 4'b0000);
        chk("reset_load_data", LOAD_DATA, 32'h0);

        snap(); s_rw = rw_hist[4'b1010];
        do_access(1, 0, 3'b010, 32'h0, 32'h0, 18);
        idle(1);
        chk("lw_miss_rw_cycles", rw_hist[4'b1010] - s_rw, 19);
        chk("lw_miss_stall_cycles", stall_cyc - s_stall, 19);
        chk("lw_miss_lv_pulses", lv_cnt - s_lv, 1);
        chk("lw_miss_stall_count", STALL_COUNT, 32'd19);
        chk("lw_miss_data", LOAD_DATA, 32'h0);

        snap(); s_rw = rw_hist[4'b1011];
        do_access(0, 1, 3'b010, 32'h0, 32'hABCD_1234, 0);
        chk("sw_rw_cycles", rw_hist[4'b1011] - s_rw, 1);
        chk("sw_stall_cycles", stall_cyc - s_stall, 1);
        chk("sw_writedata", bus.WRITEDATA, 32'hABCD_1234);
        snap(); s_rw = rw_hist[4'b1000];
        do_access(1, 0, 3'b000, 32'h0, 32'h0, 0);
        idle(1);
        chk("lb_rw_cycles", rw_hist[4'b1000] - s_rw, 1);
        chk("lb_data", LOAD_DATA, 32'h0000_0034);
        chk("lb_lv_pulses", lv_cnt - s_lv, 1);

        snap();
        present_one(1, 0, 3'b010, 32'h2);
        idle(1);
        present_one(0, 1, 3'b001, 32'h1);
        idle(1);
        chk("misaligned_pulses", mis_cnt - s_mis, 2);
        chk("misaligned_no_request", nonzero_rw() - s_nz, 0);
        chk("misaligned_no_stall", stall_cyc - s_stall, 0);
        chk("misaligned_stall_count", STALL_COUNT, 32'd21);
        chk("misaligned_no_lv", lv_cnt - s_lv, 0);

        snap();
        present_one(1, 0, 3'b011, 32'h0);
        present_one(0, 1, 3'b100, 32'h0);
        idle(1);
        chk("noop_no_request", nonzero_rw() - s_nz, 0);
        chk("noop_no_flag", mis_cnt - s_mis, 0);

        snap(); s_rw = rw_hist[4'b1011];
        do_access(1, 1, 3'b010, 32'h8, 32'h0000_0055, 0);
        chk("write_priority_rw", rw_hist[4'b1011] - s_rw, 1);
        chk("write_priority_no_lv", lv_cnt - s_lv, 0);

        snap();
        do_access(1, 0, 3'b010, 32'h10, 32'h0, 0);
        do_access(1, 0, 3'b010, 32'h14, 32'h0, 0);
        idle(1);
        chk("b2b_cycles", cyc - s_cyc, 5);
        chk("b2b_stall_cycles", stall_cyc - s_stall, 2);
        chk("b2b_lv_pulses", lv_cnt - s_lv, 2);
        chk("b2b_data0", lv_q[lv_q.size() - 2], 32'h1111_2222);
        chk("b2b_data1", lv_q[lv_q.size() - 1], 32'h3333_4444);

        snap();
        MEM_READ_EN = 1; FUNCT3 = 3'b010; ALU_RESULT = 32'h20;
        @(posedge CLK);
        #1;
        MEM_READ_EN = 0;
        bus.BUSYWAIT = 1;
        bus.READDATA = 32'hDEAD_BEEF;
        idle(4);
        RESET = 1;
        #1;
        chk("reset_abort_rw", bus.READ_WRITE, 4'b0000);
        chk("reset_abort_stall", STALL, 1'b0);
        chk("reset_abort_count", STALL_COUNT, 32'd0);
        idle(1);
        bus.BUSYWAIT = 0;
        RESET = 0;
        idle(3);
        chk("reset_abort_no_lv", lv_cnt - s_lv, 0);
        chk("reset_abort_load_data", LOAD_DATA, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
